vx_csr_access_arb: RTL

//  Arbitrates CSR instructions from NUM_REQS requesters (port 0: issue-stage CSR unit, port 1: debug/host).

---
 rtl/vx_csr_access_arb_if.sv | 47 ++++
 rtl/vx_csr_access_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_access_arb_if.sv
// vx_csr_access_arb_if: requester, response and CSR-file signals of the CSR access arbiter.
// master is the arbiter's view; slave is the view of the environment around it.
interface vx_csr_access_arb_if #(
    parameter int NUM_REQS  = 2,
    parameter int ADDR_BITS = 12,
    parameter int WID_BITS  = 2,
    parameter int UUID_BITS = 44
);
    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS-1:0]           req_ready;
    logic [NUM_REQS*2-1:0]         req_op;
    logic [NUM_REQS*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQS*WID_BITS-1:0]  req_wid;
    logic [NUM_REQS*UUID_BITS-1:0] req_uuid;
    logic [NUM_REQS*32-1:0]        req_data;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [IDX_W-1:0]              rsp_idx;
    logic [UUID_BITS-1:0]          rsp_uuid;
    logic [31:0]                   rsp_data;
    logic                          csr_read_enable;
    logic [ADDR_BITS-1:0]          csr_read_addr;
    logic [WID_BITS-1:0]           csr_read_wid;
    logic [UUID_BITS-1:0]          csr_read_uuid;
    logic [31:0]                   csr_read_data;
    logic                          csr_write_enable;
    logic [ADDR_BITS-1:0]          csr_write_addr;
    logic [WID_BITS-1:0]           csr_write_wid;
    logic [UUID_BITS-1:0]          csr_write_uuid;
    logic [31:0]                   csr_write_data;
    logic                          busy;

    modport master (
        input  req_valid, req_op, req_addr, req_wid, req_uuid, req_data, rsp_ready, csr_read_data,
        output req_ready, rsp_valid, rsp_idx, rsp_uuid, rsp_data,
        output csr_read_enable, csr_read_addr, csr_read_wid, csr_read_uuid,
        output csr_write_enable, csr_write_addr, csr_write_wid, csr_write_uuid, csr_write_data, busy
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wid, req_uuid, req_data, rsp_ready, csr_read_data,
        input  req_ready, rsp_valid, rsp_idx, rsp_uuid, rsp_data,
        input  csr_read_enable, csr_read_addr, csr_read_wid, csr_read_uuid,
        input  csr_write_enable, csr_write_addr, csr_write_wid, csr_write_uuid, csr_write_data, busy
    );
endinterface

// File: rtl/vx_csr_access_arb.sv
// vx_csr_access_arb: serialises CSR accesses from NUM_REQS requesters as read, optional write, then response.
// Define VX_CSR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module vx_csr_access_arb #(
    parameter int NUM_REQS  = 2,
    parameter int ADDR_BITS = 12,
    parameter int WID_BITS  = 2,
    parameter int UUID_BITS = 44
) (
    input logic                 clk,
    input logic                 reset,
    vx_csr_access_arb_if.master bus
);
    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WID_BITS-1:0]  wid_q, wid_d;
    logic [UUID_BITS-1:0] uuid_q, uuid_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          old_q, old_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 busy_q, busy_d;
`ifndef VX_CSR_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    logic                 found;
    logic [IDX_W-1:0]     grant;
    logic [1:0]           sel_op;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [WID_BITS-1:0]  sel_wid;
    logic [UUID_BITS-1:0] sel_uuid;
    logic [31:0]          sel_data;
    logic                 writes;
    logic [31:0]          wr_value;

    // Round-robin: first look at requesters at or above rr_ptr, then wrap to the bottom.
    always_comb begin
        found = 1'b0;
        grant = '0;
`ifndef VX_CSR_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQS; i++)
            if (!found && bus.req_valid[i] && i >= int'(rr_ptr_q)) begin
                found = 1'b1;
                grant = IDX_W'(i);
            end
`endif
        for (int i = 0; i < NUM_REQS; i++)
            if (!found && bus.req_valid[i]) begin
                found = 1'b1;
                grant = IDX_W'(i);
            end
    end

    always_comb begin
        sel_op        = '0;
        sel_addr      = '0;
        sel_wid       = '0;
        sel_uuid      = '0;
        sel_data      = '0;
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++)
            if (grant == IDX_W'(i)) begin
                sel_op           = bus.req_op[i*2 +: 2];
                sel_addr         = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wid          = bus.req_wid[i*WID_BITS +: WID_BITS];
                sel_uuid         = bus.req_uuid[i*UUID_BITS +: UUID_BITS];
                sel_data         = bus.req_data[i*32 +: 32];
                bus.req_ready[i] = found && state_q == IDLE && !reset;
            end
    end

    // Only meaningful while in READ, when csr_read_data holds the old value.
    always_comb begin
        writes   = (op_q == OP_RW) || (op_q[1] && data_q != '0);
        wr_value = (op_q == OP_RW) ? data_q :
                   (op_q == OP_RS) ? (bus.csr_read_data | data_q) : (bus.csr_read_data & ~data_q);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wid_d   = wid_q;
        uuid_d  = uuid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        old_d   = old_q;
`ifndef VX_CSR_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE:
                if (found) begin
                    state_d = READ;
                    op_d    = sel_op;
                    addr_d  = sel_addr;
                    wid_d   = sel_wid;
                    uuid_d  = sel_uuid;
                    data_d  = sel_data;
                    idx_d   = grant;
`ifndef VX_CSR_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (grant == IDX_W'(NUM_REQS - 1)) ? '0 : grant + IDX_W'(1);
`endif
                end
            READ: begin
                old_d   = bus.csr_read_data;
                state_d = writes ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        rd_en_d     = state_d == READ;
        wr_en_d     = state_d == WRITE;
        wdata_d     = wr_en_d ? wr_value : '0;
        rsp_valid_d = state_d == RESP;
        busy_d      = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wid_q       <= '0;
            uuid_q      <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            old_q       <= '0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifndef VX_CSR_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wid_q       <= wid_d;
            uuid_q      <= uuid_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            old_q       <= old_d;
            wdata_q     <= wdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifndef VX_CSR_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.csr_read_enable  = rd_en_q;
    assign bus.csr_read_addr    = addr_q;
    assign bus.csr_read_wid     = wid_q;
    assign bus.csr_read_uuid    = uuid_q;
    assign bus.csr_write_enable = wr_en_q;
    assign bus.csr_write_addr   = addr_q;
    assign bus.csr_write_wid    = wid_q;
    assign bus.csr_write_uuid   = uuid_q;
    assign bus.csr_write_data   = wdata_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_idx          = idx_q;
    assign bus.rsp_uuid         = uuid_q;
    assign bus.rsp_data         = old_q;
    assign bus.busy             = busy_q;
endmodule
